// File: rtl/step_sequencer_if.sv
// Control/status bundle between the register file, the downscaling core and
// the step sequencer. The master side drives control and the core handshake,
// and the slave side (the sequencer) returns the advance strobe and status.
interface step_sequencer_if #(
    parameter int PX_W = 16
);
    logic [7:0]      reg_f9;
    logic [PX_W-1:0] total_px;
    logic            core_ready;
    logic            core_adv;
    logic [PX_W-1:0] px_count;
    logic            busy;
    logic            done;
    logic [2:0]      state_dbg;

    modport master (
        output reg_f9,
        output total_px,
        output core_ready,
        input  core_adv,
        input  px_count,
        input  busy,
        input  done,
        input  state_dbg
    );

    modport slave (
        input  reg_f9,
        input  total_px,
        input  core_ready,
        output core_adv,
        output px_count,
        output busy,
        output done,
        output state_dbg
    );
endinterface

// File: rtl/step_sequencer.sv
// Step sequencer for the bilinear downscaling core. It runs a frame either
// continuously or one advance per step edge, counts issued advances against
// the latched pixel total, waits out the core pipeline, then reports done.
module step_sequencer #(
    parameter int PX_W     = 16,
    parameter int PIPE_LAT = 4
) (
    input logic             clk,
    input logic             aclr,
    step_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_FIRE = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    // The drain counter needs at least one bit even for a single-stage core.
    localparam int               DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT - 1);

    state_t          state;
    logic [PX_W-1:0] px_cnt;
    logic [PX_W-1:0] total_lat;
    logic [DRN_W-1:0] drain_cnt;
    logic            start_q;
    logic            step_q;

    logic step_bit;
    logic mode_bit;
    logic start_bit;
    logic abort_bit;
    logic start_rise;
    logic step_rise;
    logic core_adv_w;
    logic last;
    logic unused_ctl;

    assign step_bit   = bus.reg_f9[0];
    assign mode_bit   = bus.reg_f9[1];
    assign start_bit  = bus.reg_f9[2];
    assign abort_bit  = bus.reg_f9[3];
    assign unused_ctl = ^bus.reg_f9[7:4];

    assign start_rise = start_bit & ~start_q;
    assign step_rise  = step_bit & ~step_q;

    // Advance is combinational so the core sees it in the same cycle that
    // core_ready is asserted; abort suppresses it immediately.
    assign core_adv_w = ((state == RUN) || (state == STEP_FIRE)) &&
                        bus.core_ready && !abort_bit;
    assign last       = core_adv_w && (px_cnt == (total_lat - PX_W'(1)));

    assign bus.core_adv  = core_adv_w;
    assign bus.px_count  = px_cnt;
    assign bus.state_dbg = state;
    assign bus.busy      = (state == RUN) || (state == STEP_WAIT) ||
                           (state == STEP_FIRE) || (state == DRAIN);
    assign bus.done      = (state == DONE);

    // Sequencer FSM with edge registers, frame counter and pipeline drain.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state     <= IDLE;
            px_cnt    <= '0;
            total_lat <= '0;
            drain_cnt <= '0;
            start_q   <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            start_q <= start_bit;
            step_q  <= step_bit;

            if (core_adv_w) begin
                px_cnt <= px_cnt + PX_W'(1);
            end

            // Abort wins over every transition and discards frame progress.
            if (abort_bit && (state != IDLE)) begin
                state  <= IDLE;
                px_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_rise && !abort_bit) begin
                            total_lat <= bus.total_px;
                            px_cnt    <= '0;
                            if (bus.total_px == '0) begin
                                state <= DONE;
                            end else if (mode_bit) begin
                                state <= STEP_WAIT;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (last) begin
                            state     <= DRAIN;
                            drain_cnt <= DRN_LOAD;
                        end else if (mode_bit) begin
                            state <= STEP_WAIT;
                        end
                    end
                    STEP_WAIT: begin
                        if (step_rise) begin
                            state <= STEP_FIRE;
                        end else if (!mode_bit) begin
                            state <= RUN;
                        end
                    end
                    STEP_FIRE: begin
                        // Wait here for core_ready; extra step edges are dropped.
                        if (core_adv_w) begin
                            if (last) begin
                                state     <= DRAIN;
                                drain_cnt <= DRN_LOAD;
                            end else begin
                                state <= STEP_WAIT;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) begin
                            state <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt - DRN_W'(1);
                        end
                    end
                    DONE: begin
                        if (!start_bit) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: expected pixel indices are queued when a frame is
// started and checked against px_count on every advance the core receives.
module tb_step_sequencer;

    localparam int PX_W     = 16;
    localparam int PIPE_LAT = 4;

    logic clk = 1'b0;
    logic aclr;

    always #5 clk = ~clk;

    step_sequencer_if #(.PX_W(PX_W)) bus ();

    step_sequencer #(.PX_W(PX_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    int adv_total   = 0;
    int drain_total = 0;
    int streak      = 0;
    int last_streak = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: every advance consumes one expected index.
    always @(negedge clk) begin
        if (bus.core_adv === 1'b1) begin
            adv_total++;
            streak++;
            chk_eq("adv_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk_eq("adv_px", 32'(bus.px_count), 32'(exp_q.pop_front()));
            end
        end else begin
            if (streak > 0) last_streak = streak;
            streak = 0;
        end
        if (bus.state_dbg === 3'd4) drain_total++;
    end

    task automatic sync(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (bus.state_dbg !== s && n < budget) begin
            sync();
            n++;
        end
        chk_eq(tag, 32'(bus.state_dbg), 32'(s));
    endtask

    task automatic start_frame(input int total, input bit mode);
        bus.total_px = PX_W'(total);
        for (int i = 0; i < total; i++) exp_q.push_back(i);
        bus.reg_f9 = {4'b0000, 1'b0, 1'b1, mode, 1'b0};
        sync();
        bus.reg_f9[2] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int d0;
        int n;

        bus.reg_f9     = 8'h00;
        bus.total_px   = '0;
        bus.core_ready = 1'b1;
        aclr           = 1'b1;
        #1 aclr = 1'b0;
        #1;
        chk_eq("rst_state", 32'(bus.state_dbg), 32'd0);
        chk_eq("rst_px", 32'(bus.px_count), 32'd0);
        chk_eq("rst_flags", {29'd0, bus.busy, bus.done, bus.core_adv}, 32'd0);
        sync(2);
        aclr = 1'b1;
        sync();

        // Continuous run of 5 pixels
        a0 = adv_total;
        d0 = drain_total;
        start_frame(5, 1'b0);
        wait_state(3'd5, 40, "run_done");
        chk_eq("run_px", 32'(bus.px_count), 32'd5);
        chk_eq("run_doneflag", {30'd0, bus.busy, bus.done}, 32'd1);
        chk_eq("run_advs", 32'(adv_total - a0), 32'd5);
        chk_eq("run_streak", 32'(last_streak), 32'd5);
        chk_eq("run_drain", 32'(drain_total - d0), 32'(PIPE_LAT));
        chk_eq("run_q", 32'(exp_q.size()), 32'd0);
        sync();
        chk_eq("run_idle", 32'(bus.state_dbg), 32'd0);
        chk_eq("run_px_hold", 32'(bus.px_count), 32'd5);

        // Single-step frame of 3 pixels
        a0 = adv_total;
        d0 = drain_total;
        start_frame(3, 1'b1);
        chk_eq("step_wait", 32'(bus.state_dbg), 32'd2);
        for (int k = 0; k < 3; k++) begin
            sync(10);
            chk_eq("step_gap", 32'(adv_total - a0), 32'(k));
            bus.reg_f9[0] = 1'b1;
            sync();
            bus.reg_f9[0] = 1'b0;
            if (k < 2) begin
                sync(3);
                chk_eq("step_one", 32'(adv_total - a0), 32'(k + 1));
                chk_eq("step_back", 32'(bus.state_dbg), 32'd2);
            end else begin
                sync(4);
                chk_eq("step_drain", 32'(bus.state_dbg), 32'd4);
                sync();
                chk_eq("step_done", 32'(bus.state_dbg), 32'd5);
            end
        end
        chk_eq("step_px", 32'(bus.px_count), 32'd3);
        chk_eq("step_drain_len", 32'(drain_total - d0), 32'(PIPE_LAT));
        bus.reg_f9 = 8'h00;
        sync();
        chk_eq("step_idle", 32'(bus.state_dbg), 32'd0);

        // Backpressure in step mode with extra step edges while stalled
        a0 = adv_total;
        start_frame(2, 1'b1);
        bus.core_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.reg_f9[0] = (i % 2 == 0);
            sync();
        end
        bus.reg_f9[0] = 1'b0;
        chk_eq("bp_hold", 32'(bus.state_dbg), 32'd3);
        chk_eq("bp_noadv", 32'(adv_total - a0), 32'd0);
        bus.core_ready = 1'b1;
        sync(3);
        chk_eq("bp_once", 32'(adv_total - a0), 32'd1);
        chk_eq("bp_px", 32'(bus.px_count), 32'd1);
        chk_eq("bp_wait", 32'(bus.state_dbg), 32'd2);
        bus.reg_f9[0] = 1'b1;
        sync();
        bus.reg_f9[0] = 1'b0;
        wait_state(3'd5, 20, "bp_done");
        chk_eq("bp_px_end", 32'(bus.px_count), 32'd2);
        bus.reg_f9 = 8'h00;
        sync();

        // Mode switch mid-frame: the advance in the switching cycle counts
        a0 = adv_total;
        start_frame(100, 1'b0);
        n = 0;
        while (bus.px_count != 16'd10 && n < 200) begin
            sync();
            n++;
        end
        chk_eq("ms_px10", 32'(bus.px_count), 32'd10);
        bus.reg_f9[1] = 1'b1;
        sync();
        chk_eq("ms_wait", 32'(bus.state_dbg), 32'd2);
        chk_eq("ms_px11", 32'(bus.px_count), 32'd11);
        sync(5);
        chk_eq("ms_hold", 32'(bus.px_count), 32'd11);
        bus.reg_f9[1] = 1'b0;
        sync();
        chk_eq("ms_run", 32'(bus.state_dbg), 32'd1);
        wait_state(3'd5, 300, "ms_done");
        chk_eq("ms_px100", 32'(bus.px_count), 32'd100);
        chk_eq("ms_advs", 32'(adv_total - a0), 32'd100);
        sync();

        // Abort at px_count 40
        a0 = adv_total;
        start_frame(100, 1'b0);
        n = 0;
        while (bus.px_count != 16'd40 && n < 200) begin
            sync();
            n++;
        end
        bus.reg_f9[3] = 1'b1;
        sync();
        chk_eq("abort_state", 32'(bus.state_dbg), 32'd0);
        chk_eq("abort_px", 32'(bus.px_count), 32'd0);
        chk_eq("abort_flags", {30'd0, bus.busy, bus.done}, 32'd0);
        chk_eq("abort_advs", 32'(adv_total - a0), 32'd40);
        exp_q.delete();
        bus.reg_f9 = 8'h00;
        sync();

        // Asynchronous reset in DRAIN
        start_frame(3, 1'b0);
        wait_state(3'd4, 20, "rst_drain");
        #2 aclr = 1'b0;
        #1;
        chk_eq("arst_state", 32'(bus.state_dbg), 32'd0);
        chk_eq("arst_px", 32'(bus.px_count), 32'd0);
        chk_eq("arst_flags", {29'd0, bus.busy, bus.done, bus.core_adv}, 32'd0);
        exp_q.delete();
        sync();
        aclr = 1'b1;
        sync();

        // Start is ignored in IDLE while abort is held
        bus.total_px = 16'd4;
        bus.reg_f9   = 8'h0C;
        sync(2);
        chk_eq("abort_start_ign", 32'(bus.state_dbg), 32'd0);
        bus.reg_f9 = 8'h00;
        sync();

        // Zero-length frame with start held high through DONE
        a0 = adv_total;
        bus.total_px = '0;
        bus.reg_f9   = 8'h04;
        sync();
        chk_eq("zero_done", 32'(bus.state_dbg), 32'd5);
        chk_eq("zero_doneflag", 32'(bus.done), 32'd1);
        sync(5);
        chk_eq("zero_hold", 32'(bus.state_dbg), 32'd5);
        chk_eq("zero_noadv", 32'(adv_total - a0), 32'd0);
        bus.reg_f9 = 8'h00;
        sync();
        chk_eq("zero_idle", 32'(bus.state_dbg), 32'd0);

        // Held start through a real frame, then a fresh edge restarts
        start_frame(2, 1'b0);
        bus.reg_f9[2] = 1'b1;
        wait_state(3'd5, 20, "held_done");
        sync(4);
        chk_eq("held_stay", 32'(bus.state_dbg), 32'd5);
        bus.reg_f9 = 8'h00;
        sync();
        chk_eq("held_idle", 32'(bus.state_dbg), 32'd0);
        sync(2);
        chk_eq("held_no_retrig", 32'(bus.state_dbg), 32'd0);
        start_frame(1, 1'b0);
        chk_eq("retrig_run", 32'(bus.state_dbg), 32'd1);
        wait_state(3'd5, 20, "retrig_done");
        chk_eq("final_q", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
